// File: rtl/serial_adder_ctrl_if.sv
// Handshake/data bundle for serial_adder_ctrl. SERIAL_ADDER_SUB_EN adds the sub request bit.
// start is sampled only while idle; busy marks the WIDTH processing cycles; done pulses once when sum/cout update.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       fsm_state;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, fsm_state);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, fsm_state);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, fsm_state);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, fsm_state);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one gate-level full adder sequenced over WIDTH cycles, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub request (a - b via inverted b and carry-in 1).
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    logic g;
    logic t;

    xor u_xor_p (p, x, y);
    xor u_xor_s (s, p, ci);
    and u_and_g (g, x, y);
    and u_and_t (t, p, ci);
    or  u_or_co (co, g, t);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic               clk,
    input logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so cout=1 means no borrow.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    full_adder u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    assign last_bit = (cnt == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_sh  <= {s_bit, r_sh[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= c_bit;
                    cnt   <= cnt + 1'b1;
                    // The final sum bit is still in flight, so take it straight from the cell.
                    if (last_bit) begin
                        sum_q  <= {s_bit, r_sh[WIDTH-1:1]};
                        cout_q <= c_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8, including the SERIAL_ADDER_SUB_EN vectors when defined.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    vec_t tab[20];
    int   n_tab;
    logic [W:0] exp_q[$];
    logic [W:0] last_result;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input logic [W-1:0] s, input logic co);
        tab[n_tab] = '{a: a, b: b, cin: cin, sub: sub, exp_sum: s, exp_cout: co};
        n_tab++;
    endtask

    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.start = st;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sub;
`else
        if (sub) bus.cin = cin;
`endif
    endtask

    // Issues start, checks the WIDTH busy cycles, returns in the done cycle.
    // poke >= 0 raises start (with a=0) during that RUN cycle to prove it is ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W:0] exp, input int poke);
        logic [W:0] want;
        exp_q.push_back(exp);
        drive(1'b1, a, b, cin, sub);
        tick();
        for (int i = 0; i < W; i++) begin
            check("busy_run", bus.busy, 1);
            check("done_run", bus.done, 0);
            check("sum_held", {bus.cout, bus.sum}, last_result);
            if (i == poke) drive(1'b1, '0, W'($urandom_range(0, 255)), 1'b1, 1'b0);
            else drive(1'b0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
        bus.start = 1'b0;
        want = exp_q.pop_front();
        check("done_pulse", bus.done, 1);
        check("busy_done", bus.busy, 0);
        check("result", {bus.cout, bus.sum}, want);
        last_result = want;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_tab = 0;
        last_result = '0;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        add_vec(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0);
        add_vec(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        add_vec(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        add_vec(8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);
        add_vec(8'h00, 8'h01, 1'b1, 1'b0, 8'h02, 1'b0);
        add_vec(8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
        add_vec(8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0);
        add_vec(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
        add_vec(8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0);
        add_vec(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        add_vec(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        add_vec(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        add_vec(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
        add_vec(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        add_vec(8'h20, 8'h05, 1'b0, 1'b1, 8'h1B, 1'b1);
        add_vec(8'h05, 8'h20, 1'b1, 1'b1, 8'hE5, 1'b0);
        add_vec(8'h42, 8'h42, 1'b0, 1'b1, 8'h00, 1'b1);
        add_vec(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);
`endif

        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_state", bus.fsm_state, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);

        for (int i = 0; i < n_tab; i++) begin
            run_op(tab[i].a, tab[i].b, tab[i].cin, tab[i].sub,
                   {tab[i].exp_cout, tab[i].exp_sum}, -1);
            tick();
            check("post_done", bus.done, 0);
            check("post_busy", bus.busy, 0);
        end

        // start during RUN is dropped; start held through DONE is taken one cycle later.
        run_op(8'h10, 8'h20, 1'b0, 1'b0, {1'b0, 8'h30}, 2);
        drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        check("start_in_done_busy", bus.busy, 0);
        check("start_in_done_sum", bus.sum, 8'h30);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, {1'b0, 8'h03}, -1);
        tick();

        // Reset during RUN aborts and clears the result.
        drive(1'b1, 8'h55, 8'hAA, 1'b0, 1'b0);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", bus.busy, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_cout", bus.cout, 0);
        for (int i = 0; i < W + 2; i++) begin
            check("abort_no_done", bus.done, 0);
            tick();
        end
        last_result = '0;
        run_op(8'h55, 8'hAA, 1'b0, 1'b0, {1'b0, 8'hFF}, -1);
        tick();

        // Reset wins over a simultaneous start.
        rst_n = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);
        check("rst_start_sum", bus.sum, 0);
        tick();
        check("rst_start_still_idle", bus.busy, 0);
        check("rst_start_state", bus.fsm_state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. It sequences one 1-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- The full-adder cell is one instance of the team's existing structural gate-level full adder.
- The controller owns operand shift registers, the carry flip-flop, the bit counter, the result register and a start/busy/done handshake.
- It trades latency for area and gives the gate-level adder its first sequential wrapper.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..64.
- CNT_W, $clog2(WIDTH)+1, bit-counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new addition. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepted start edge.
- b  input  WIDTH  operand B. Captured on the accepted start edge.
- cin  input  1  carry-in. Captured on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout are valid.
- sum  output  WIDTH  registered result. Held until the next completion.
- cout  output  1  registered carry-out. Held until the next completion.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset: state=IDLE, counter=0, carry=0, shift registers=0, busy=0, done=0, sum=0, cout=0.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE:
  - On an edge with start=1: load A_sh<=a, B_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - With start=0: stay in IDLE.
- RUN, every edge:
  - The full-adder cell computes s_bit and c_bit from A_sh[0], B_sh[0] and carry.
  - R_sh<={s_bit, R_sh[WIDTH-1:1]}.
  - A_sh and B_sh shift right by 1 with zero fill.
  - carry<=c_bit and cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge: also load sum<={s_bit, R_sh[WIDTH-1:1]} and cout<=c_bit, then go to DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency: start accepted at edge k. busy=1 during the WIDTH cycles following edges k..k+WIDTH-1. done=1 for the one cycle after edge k+WIDTH. sum/cout change only at edge k+WIDTH.
- Back-to-back operation: the earliest next accept is the edge that leaves DONE+1, i.e. one idle cycle between operations.
- start while busy or in DONE: ignored, not queued. The a/b/cin inputs may change freely after acceptance.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- Reset mid-operation: rst_n=0 at any edge aborts the operation immediately. All state returns to reset values, no done pulse is produced, and sum/cout are cleared to 0.
- Simultaneous rst_n=0 and start=1: reset wins; start is not accepted.
- Boundary cases:
  - All-ones operands with cin=1 give sum=all-ones, cout=1.
  - Zero operands give sum=0, cout=0 with the full WIDTH-cycle latency. There is no early exit.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands on the accepted start edge.
  - If sub=1: B_sh<=~b and carry<=1. cin is ignored.
  - Result is sum=a-b mod 2^WIDTH, and cout=1 means no borrow (a>=b unsigned).
  - If sub=0: behaviour is identical to the base add.
- Undefined: the sub port does not exist and the block is add-only.

Test Plan (WIDTH=8):
- After reset, start with a=8'h3C, b=8'h5A, cin=0 -> busy high for 8 cycles, done pulse on cycle 9, sum=8'h96, cout=0. Also sweep all 8 full-adder input combinations via a=1/b=0/1, cin=0/1 in bit 0.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- Accept a=8'h10, b=8'h20. Pulse start again with a=8'h00 at cycle 3 of RUN -> ignored, result sum=8'h30. A start in the cycle after done is accepted.
- Start a=8'h55, b=8'hAA. Drop rst_n for one edge at cycle 4 -> busy=0, done never pulses, sum=0, cout=0. The next start runs cleanly.
- rst_n=0 and start=1 on the same edge -> stays in IDLE, busy=0.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h20, b=8'h05 -> sum=8'h1B, cout=1.
  - sub=1, a=8'h05, b=8'h20 -> sum=8'hE5, cout=0.
